board_init: RTL and testbench

// - Fills the game board memory with random cell colours after the setup menu requests a new game.
// - Sits between the menu/select stage and the board RAM/VGA renderer.
// - Consumes the menu's INITIALIZE_BOARD level, SIZE and COLOR_NUM; returns BOARD_READY,

---
 rtl/flood_pkg.sv | 48 ++++
 rtl/lfsr16.sv | 46 ++++
 rtl/board_init.sv | 188 ++++++++++++++++++
 tb/tb_board_init.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flood_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package     : flood_pkg                                                     |
// | Description : Shared constants, FSM encoding and input-legalisation helpers |
// |               for the board initialiser and its LFSR.                       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package flood_pkg;

    localparam int          MAX_SIZE     = 26;
    localparam int          ADDR_W       = 10;
    localparam int          COLOR_W      = 3;
    localparam int          LFSR_W       = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] c_LFSR_TAPS  = 16'hB400;

    localparam logic [4:0]  c_SIZE_MIN      = 5'd2;
    localparam logic [4:0]  c_SIZE_MAX      = 5'd26;
    localparam logic [4:0]  c_SIZE_DEFAULT  = 5'd14;
    localparam logic [3:0]  c_COLOR_MIN     = 4'd3;
    localparam logic [3:0]  c_COLOR_MAX     = 4'd8;
    localparam logic [3:0]  c_COLOR_DEFAULT = 4'd6;

    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_SEED = 2'd1;
    localparam logic [1:0]  c_ST_FILL = 2'd2;
    localparam logic [1:0]  c_ST_DONE = 2'd3;

    // Legal edges are 2,6,...,26: in range and congruent to 2 mod 4.
    function automatic logic [4:0] legal_size(input logic [4:0] s);
        if ((s >= c_SIZE_MIN) && (s <= c_SIZE_MAX) && (s[1:0] == 2'b10)) begin
            return s;
        end
        return c_SIZE_DEFAULT;
    endfunction

    function automatic logic [3:0] legal_colors(input logic [3:0] c);
        if ((c >= c_COLOR_MIN) && (c <= c_COLOR_MAX)) begin
            return c;
        end
        return c_COLOR_DEFAULT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : lfsr16                                                        |
// | Description : 16-bit right-shifting Galois LFSR with parallel load.         |
// |               LOAD has priority over STEP; otherwise the value holds.       |
// | Ports       : MASTER_CLOCK, RESET (sync, active-high), LOAD, LOAD_VAL[15:0],|
// |               STEP, Q[15:0]                                                 |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module lfsr16 #(
    parameter logic [15:0] RESET_VAL = flood_pkg::DEFAULT_SEED
) (
    input  logic        MASTER_CLOCK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [15:0] LOAD_VAL,
    input  logic        STEP,
    output logic [15:0] Q
);
    import flood_pkg::*;

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (LOAD) begin
            w_lfsr_nxt = LOAD_VAL;
        end else if (STEP) begin
            w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (RESET) begin
            r_lfsr <= RESET_VAL;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign Q = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/board_init.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : board_init                                                    |
// | Description : Fills the game-board RAM with random colours after the menu   |
// |               requests a new game, then raises BOARD_READY.                 |
// | Ports       : MASTER_CLOCK, RESET     clock / sync active-high reset        |
// |               START                   level request from the menu           |
// |               SIZE[4:0], COLOR_NUM[3:0] board edge and colour count         |
// |               SEED_IN[15:0]           switch-bank seed                      |
// |               WR_EN, WR_ADDR, WR_COLOR board RAM write port                 |
// |               BUSY, BOARD_READY       status to menu                        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module board_init #(
    parameter int          MAX_SIZE     = flood_pkg::MAX_SIZE,
    parameter int          ADDR_W       = flood_pkg::ADDR_W,
    parameter int          COLOR_W      = flood_pkg::COLOR_W,
    parameter int          LFSR_W       = flood_pkg::LFSR_W,
    parameter logic [15:0] DEFAULT_SEED = flood_pkg::DEFAULT_SEED,
    parameter bit          USE_ENTROPY  = 1'b1
) (
    input  logic               MASTER_CLOCK,
    input  logic               RESET,
    input  logic               START,
    input  logic [4:0]         SIZE,
    input  logic [3:0]         COLOR_NUM,
    input  logic [15:0]        SEED_IN,
    output logic               WR_EN,
    output logic [ADDR_W-1:0]  WR_ADDR,
    output logic [COLOR_W-1:0] WR_COLOR,
    output logic               BUSY,
    output logic               BOARD_READY
);
    import flood_pkg::*;

    logic [1:0]         r_state,    w_state_nxt;
    logic [4:0]         r_size,     w_size_nxt;
    logic [3:0]         r_colors,   w_colors_nxt;
    logic [4:0]         r_row,      w_row_nxt;
    logic [4:0]         r_col,      w_col_nxt;
    logic [LFSR_W-1:0]  r_entropy;
    logic               r_wr_en,    w_wr_en_nxt;
    logic [ADDR_W-1:0]  r_wr_addr,  w_wr_addr_nxt;
    logic [COLOR_W-1:0] r_wr_color, w_wr_color_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_ready,    w_ready_nxt;

    logic [LFSR_W-1:0]  w_lfsr_q;
    logic               w_lfsr_load;
    logic               w_lfsr_step;
    logic [LFSR_W-1:0]  w_seed_mix;
    logic [LFSR_W-1:0]  w_seed_val;
    logic [COLOR_W-1:0] w_sample;
    logic               w_accept;
    logic               w_col_last;
    logic               w_row_last;
    logic [ADDR_W-1:0]  w_cell_addr;
    logic               w_unused_lfsr;

    lfsr16 #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .MASTER_CLOCK (MASTER_CLOCK),
        .RESET        (RESET),
        .LOAD         (w_lfsr_load),
        .LOAD_VAL     (w_seed_val),
        .STEP         (w_lfsr_step),
        .Q            (w_lfsr_q)
    );

    // Only the low colour bits are sampled; the rest of the state is internal.
    assign w_unused_lfsr = ^w_lfsr_q[LFSR_W-1:COLOR_W];

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    assign w_seed_mix = SEED_IN ^ (USE_ENTROPY ? r_entropy : {LFSR_W{1'b0}});
    assign w_seed_val = (w_seed_mix == '0) ? DEFAULT_SEED : w_seed_mix;

    assign w_sample    = w_lfsr_q[COLOR_W-1:0];
    assign w_accept    = (4'(w_sample) < r_colors);
    assign w_col_last  = (r_col == (r_size - 5'd1));
    assign w_row_last  = (r_row == (r_size - 5'd1));
    assign w_cell_addr = ADDR_W'(r_row) * ADDR_W'(MAX_SIZE) + ADDR_W'(r_col);

    always_comb begin
        w_state_nxt    = r_state;
        w_size_nxt     = r_size;
        w_colors_nxt   = r_colors;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_color_nxt = r_wr_color;
        w_ready_nxt    = 1'b0;
        w_lfsr_load    = 1'b0;
        w_lfsr_step    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (START) begin
                    w_size_nxt   = legal_size(SIZE);
                    w_colors_nxt = legal_colors(COLOR_NUM);
                    w_state_nxt  = c_ST_SEED;
                end
            end
            c_ST_SEED: begin
                if (!START) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_lfsr_load = 1'b1;
                    w_row_nxt   = 5'd0;
                    w_col_nxt   = 5'd0;
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                w_lfsr_step = 1'b1;
                if (!START) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_accept) begin
                    // Rejected samples leave the cell position untouched and retry.
                    w_wr_en_nxt    = 1'b1;
                    w_wr_addr_nxt  = w_cell_addr;
                    w_wr_color_nxt = w_sample;
                    if (w_col_last) begin
                        w_col_nxt = 5'd0;
                        if (w_row_last) begin
                            w_state_nxt = c_ST_DONE;
                        end else begin
                            w_row_nxt = r_row + 5'd1;
                        end
                    end else begin
                        w_col_nxt = r_col + 5'd1;
                    end
                end
            end
            c_ST_DONE: begin
                // A held START never restarts; the menu must drop it first.
                if (!START) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == c_ST_SEED) || (w_state_nxt == c_ST_FILL);
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (RESET) begin
            r_state    <= c_ST_IDLE;
            r_size     <= c_SIZE_DEFAULT;
            r_colors   <= c_COLOR_DEFAULT;
            r_row      <= 5'd0;
            r_col      <= 5'd0;
            r_entropy  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_color <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_size     <= w_size_nxt;
            r_colors   <= w_colors_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_entropy  <= r_entropy + 1'b1;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_color <= w_wr_color_nxt;
            r_busy     <= w_busy_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign WR_EN       = r_wr_en;
    assign WR_ADDR     = r_wr_addr;
    assign WR_COLOR    = r_wr_color;
    assign BUSY        = r_busy;
    assign BOARD_READY = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_board_init.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_board_init                                                 |
// | Description : Self-checking bench for board_init: a queue-based model of   |
// |               each fill is compared against the DUT every cycle, plus      |
// |               directed scenarios with hand-computed expectations.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_board_init;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  size;
    logic [3:0]  colors;
    logic [15:0] seed_in;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [2:0]  wr_color;
    logic        busy;
    logic        ready;

    always #5 clk = ~clk;

    board_init #(
        .USE_ENTROPY (1'b0)
    ) dut (
        .MASTER_CLOCK (clk),
        .RESET        (rst),
        .START        (start),
        .SIZE         (size),
        .COLOR_NUM    (colors),
        .SEED_IN      (seed_in),
        .WR_EN        (wr_en),
        .WR_ADDR      (wr_addr),
        .WR_COLOR     (wr_color),
        .BUSY         (busy),
        .BOARD_READY  (ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       wr;
        logic [9:0] addr;
        logic [2:0] color;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t e;
    exp_t q[$];
    bit   e_valid = 1'b0;
    bit   e_rst   = 1'b0;
    int   mode    = 0;      // 0 idle, 1 fill request active, 2 board ready
    bit   pending = 1'b0;
    int   lat_size;
    int   lat_cn;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int legal_size_m(input int s);
        return (s >= 2 && s <= 26 && (s % 4) == 2) ? s : 14;
    endfunction

    function automatic int legal_cn_m(input int c);
        return (c >= 3 && c <= 8) ? c : 6;
    endfunction

    // One entry per fill cycle: what the write port shows after that cycle.
    task automatic build_fill(input int sz, input int cn, input logic [15:0] seed);
        logic [15:0] v;
        int r;
        int c;
        int guard;
        exp_t x;
        v = (seed == 16'h0) ? 16'hACE1 : seed;
        r = 0;
        c = 0;
        guard = 0;
        q.delete();
        while (r < sz && guard < 200000) begin
            x = '0;
            x.busy = 1'b1;
            if (int'(v[2:0]) < cn) begin
                x.wr    = 1'b1;
                x.addr  = 10'(r * 26 + c);
                x.color = v[2:0];
                c++;
                if (c == sz) begin
                    c = 0;
                    r++;
                end
                if (r == sz) x.busy = 1'b0;
            end
            q.push_back(x);
            v = lfsr_step(v);
            guard++;
        end
    endtask

    always @(posedge clk) begin
        e_valid = 1'b1;
        if (rst) begin
            e       = '0;
            e_rst   = 1'b1;
            mode    = 0;
            pending = 1'b0;
            q.delete();
        end else begin
            e_rst = 1'b0;
            if (mode == 0) begin
                e.wr = 1'b0; e.busy = 1'b0; e.ready = 1'b0;
                if (start) begin
                    lat_size = legal_size_m(int'(size));
                    lat_cn   = legal_cn_m(int'(colors));
                    e.busy   = 1'b1;
                    pending  = 1'b1;
                    mode     = 1;
                end
            end else if (mode == 1) begin
                if (!start) begin
                    e.wr = 1'b0; e.busy = 1'b0; e.ready = 1'b0;
                    mode = 0; pending = 1'b0;
                    q.delete();
                end else if (pending) begin
                    build_fill(lat_size, lat_cn, seed_in);
                    pending = 1'b0;
                    e.wr = 1'b0; e.busy = 1'b1;
                end else if (q.size() > 0) begin
                    e = q.pop_front();
                end else begin
                    e.wr = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
                    mode = 2;
                end
            end else begin
                if (!start) begin
                    e.ready = 1'b0;
                    mode = 0;
                end
            end
        end
    end

    // ---------------- compare + statistics ----------------
    int   cyc = 0;
    int   wr_count = 0;
    int   dup = 0;
    int   first_wr = -1;
    int   last_wr = -1;
    int   last_addr = 0;
    int   max_color = 0;
    bit   ready_seen = 1'b0;
    bit   seen [0:1023];
    int   col_q[$];
    int   addr_q[$];

    always @(negedge clk) begin
        if (e_valid) begin
            check("wr_en", int'(wr_en), int'(e.wr));
            check("busy", int'(busy), int'(e.busy));
            check("board_ready", int'(ready), int'(e.ready));
            if (e.wr || e_rst) begin
                check("wr_addr", int'(wr_addr), int'(e.addr));
                check("wr_color", int'(wr_color), int'(e.color));
            end
        end
        cyc++;
        if (wr_en) begin
            wr_count++;
            if (seen[wr_addr]) dup++;
            seen[wr_addr] = 1'b1;
            col_q.push_back(int'(wr_color));
            addr_q.push_back(int'(wr_addr));
            last_addr = int'(wr_addr);
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (int'(wr_color) > max_color) max_color = int'(wr_color);
        end
        if (ready) ready_seen = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        wr_count = 0; dup = 0; first_wr = -1; last_wr = -1;
        last_addr = 0; max_color = 0; ready_seen = 1'b0;
        foreach (seen[i]) seen[i] = 1'b0;
        col_q.delete();
        addr_q.delete();
    endtask

    task automatic wait_ready(input int budget, input string name, output int k);
        k = 0;
        while (!ready && k < budget) begin
            tick(1);
            k++;
        end
        check(name, int'(ready), 1);
    endtask

    initial begin
        int k;
        int cnt;
        int exp_addr [4];
        int exp_col  [4];
        exp_addr = '{0, 1, 26, 27};
        exp_col  = '{2, 1, 0, 2};

        rst = 1'b1; start = 1'b0; size = 5'd2; colors = 4'd3; seed_in = 16'h1234;
        tick(3);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_addr", int'(wr_addr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(ready), 0);
        rst = 1'b0;
        tick(2);

        check("model_step_ace1", int'(lfsr_step(seed_in ^ 16'hBED5)), 16'hE270);

        // SIZE=2, COLOR_NUM=3, seed 1234, twice
        for (int run = 0; run < 2; run++) begin
            clear_stats();
            start = 1'b1;
            wait_ready(100, "a_ready", k);
            check("a_ready_cycles", k, 12);
            check("a_writes", wr_count, 4);
            for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
                check("a_addr", addr_q[i], exp_addr[i]);
                check("a_color", col_q[i], exp_col[i]);
            end
            start = 1'b0;
            tick(3);
            check("a_ready_drop", int'(ready), 0);
        end

        // SIZE=26, COLOR_NUM=8: no rejects
        clear_stats();
        size = 5'd26; colors = 4'd8; seed_in = 16'hBEEF;
        start = 1'b1;
        wait_ready(2000, "b_ready", k);
        check("b_writes", wr_count, 676);
        check("b_dups", dup, 0);
        check("b_consecutive", last_wr - first_wr, 675);
        check("b_last_addr", last_addr, 675);
        start = 1'b0;
        tick(3);

        // Abort after 50 writes, then a full 14x14 fill
        clear_stats();
        size = 5'd14; colors = 4'd6; seed_in = 16'h0F0F;
        start = 1'b1;
        k = 0;
        while (wr_count < 50 && k < 2000) begin
            tick(1);
            k++;
        end
        check("c_reached_50", int'(wr_count >= 50), 1);
        start = 1'b0;
        tick(3);
        cnt = wr_count;
        tick(20);
        check("c_no_more_writes", wr_count, cnt);
        check("c_stop_bound", int'(wr_count <= 51), 1);
        check("c_ready_never", int'(ready_seen), 0);
        check("c_idle_busy", int'(busy), 0);
        clear_stats();
        start = 1'b1;
        wait_ready(3000, "c_ready", k);
        check("c_writes", wr_count, 196);
        check("c_dups", dup, 0);
        check("c_last_addr", last_addr, 351);
        start = 1'b0;
        tick(3);

        // Illegal SIZE/COLOR_NUM, changed after latching
        clear_stats();
        size = 5'd5; colors = 4'd12; seed_in = 16'h1357;
        start = 1'b1;
        tick(3);
        size = 5'd26; colors = 4'd8;
        wait_ready(3000, "d_ready", k);
        check("d_writes", wr_count, 196);
        check("d_last_addr", last_addr, 351);
        check("d_color_lt6", int'(max_color < 6), 1);
        start = 1'b0;
        tick(3);

        // Zero seed falls back to ACE1; START held in DONE
        clear_stats();
        size = 5'd2; colors = 4'd3; seed_in = 16'h0000;
        start = 1'b1;
        wait_ready(200, "e_ready", k);
        check("e_writes", wr_count, 4);
        check("e_first_color", (col_q.size() > 0) ? col_q[0] : -1, 1);
        cnt = wr_count;
        tick(100);
        check("e_hold_ready", int'(ready), 1);
        check("e_no_restart", wr_count, cnt);
        check("e_hold_busy", int'(busy), 0);
        start = 1'b0;
        tick(2);
        check("e_ready_low", int'(ready), 0);

        // Reset mid-fill
        clear_stats();
        size = 5'd26; colors = 4'd8; seed_in = 16'h5555;
        start = 1'b1;
        tick(30);
        check("f_filling", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        check("f_rst_wr_en", int'(wr_en), 0);
        check("f_rst_addr", int'(wr_addr), 0);
        check("f_rst_color", int'(wr_color), 0);
        check("f_rst_busy", int'(busy), 0);
        check("f_rst_ready", int'(ready), 0);
        rst = 1'b0;
        start = 1'b0;
        tick(1);
        check("f_after_wr_en", int'(wr_en), 0);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
